// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the MIPS CPU memory-bus arbiter.
package mips_cpu_bus_pkg;

    typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    localparam int         MEM_ADDR_W = 24;
    localparam logic [3:0] BYTEEN_ALL = 4'b1111;

endpackage

// File: rtl/mips_cpu_bus_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one wait-stalled memory bus.
// Define MIPS_CPU_BUS_ARB_RR_EN for round-robin on simultaneous requests (default: d over i).
module mips_cpu_bus_arbiter
    import mips_cpu_bus_pkg::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_write,
    input  logic [31:0]           d_addr,
    input  logic [3:0]            d_byteenable,
    input  logic [31:0]           d_writedata,
    output logic                  d_done,
    output logic [31:0]           rdata,
    output logic                  err,
    output logic                  m_read,
    output logic                  m_write,
    output logic [MEM_ADDR_W-1:0] m_addr,
    output logic [3:0]            m_byteenable,
    output logic [31:0]           m_writedata,
    input  logic                  m_waitrequest,
    input  logic [31:0]           m_readdata
);

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_t     state;
    port_t      grant;
    logic       is_write;
    logic       null_cmd;
    logic [7:0] wait_cnt;
    logic       pick_d;
    logic       unused_addr_hi;

    assign unused_addr_hi = ^{i_addr[31:MEM_ADDR_W], d_addr[31:MEM_ADDR_W]};

`ifdef MIPS_CPU_BUS_ARB_RR_EN
    port_t last_grant;

    always_comb begin
        pick_d = d_req && (!i_req || last_grant == PORT_I);
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            grant        <= PORT_I;
            is_write     <= 1'b0;
            null_cmd     <= 1'b0;
            wait_cnt     <= 8'd0;
            i_done       <= 1'b0;
            d_done       <= 1'b0;
            err          <= 1'b0;
            rdata        <= '0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_addr       <= '0;
            m_byteenable <= '0;
            m_writedata  <= '0;
`ifdef MIPS_CPU_BUS_ARB_RR_EN
            last_grant   <= PORT_I;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        wait_cnt    <= 8'd0;
                        m_writedata <= d_writedata;
`ifdef MIPS_CPU_BUS_ARB_RR_EN
                        last_grant  <= pick_d ? PORT_D : PORT_I;
`endif
                        if (pick_d) begin
                            grant        <= PORT_D;
                            is_write     <= d_write;
                            m_addr       <= d_addr[MEM_ADDR_W-1:0];
                            m_byteenable <= d_byteenable;
                            // No lanes enabled: nothing to put on the bus, finish with zero data.
                            if (d_byteenable == 4'b0000) begin
                                null_cmd <= 1'b1;
                                state    <= RESP;
                            end else begin
                                m_read  <= !d_write;
                                m_write <= d_write;
                                state   <= CMD;
                            end
                        end else begin
                            grant        <= PORT_I;
                            is_write     <= 1'b0;
                            m_addr       <= i_addr[MEM_ADDR_W-1:0];
                            m_byteenable <= BYTEEN_ALL;
                            m_read       <= 1'b1;
                            state        <= CMD;
                        end
                    end
                end
                CMD: begin
                    if (!m_waitrequest) begin
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        if (is_write) begin
                            i_done <= (grant == PORT_I);
                            d_done <= (grant == PORT_D);
                            err    <= 1'b0;
                            state  <= DONE;
                        end else begin
                            state <= RESP;
                        end
                    end else if (wait_cnt == WAIT_LIM) begin
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        rdata   <= '0;
                        i_done  <= (grant == PORT_I);
                        d_done  <= (grant == PORT_D);
                        err     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    rdata    <= null_cmd ? 32'd0 : m_readdata;
                    null_cmd <= 1'b0;
                    i_done   <= (grant == PORT_I);
                    d_done   <= (grant == PORT_D);
                    err      <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    err    <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Scoreboard bench for mips_cpu_bus_arbiter with a small wait-state memory model.
module tb_mips_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, d_req, d_write;
    logic [31:0] i_addr, d_addr, d_writedata;
    logic [3:0]  d_byteenable;
    logic        i_done, d_done, err, m_read, m_write, m_waitrequest;
    logic [31:0] rdata, m_writedata, m_readdata;
    logic [23:0] m_addr;
    logic [3:0]  m_byteenable;

    mips_cpu_bus_arbiter #(.WAIT_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr),
        .d_byteenable(d_byteenable), .d_writedata(d_writedata), .d_done(d_done),
        .rdata(rdata), .err(err),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata)
    );

    always #5 clk = ~clk;

`ifdef MIPS_CPU_BUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word array, stalls the first wait_cfg cycles of every command.
    logic [31:0] mem [0:255];
    int          stall_cnt = 0;
    int          wait_cfg;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] <= 32'd0;
        mem[4] <= 32'h8C010004;
    end

    assign m_waitrequest = (stall_cnt < wait_cfg);

    always @(posedge clk) begin
        if (m_read || m_write) stall_cnt <= stall_cnt + 1;
        else                   stall_cnt <= 0;
        if (m_read && !m_waitrequest) m_readdata <= mem[m_addr[9:2]];
        if (m_write && !m_waitrequest)
            for (int b = 0; b < 4; b++)
                if (m_byteenable[b]) mem[m_addr[9:2]][8*b +: 8] <= m_writedata[8*b +: 8];
    end

    typedef struct {
        bit          is_d;
        bit          err;
        bit          chk;
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   fails   = 0;
    int   rd_hi   = 0;
    int   strobe_hi = 0;
    logic [23:0] cmd_addr = '0;
    logic [3:0]  cmd_be   = '0;
    logic [31:0] cmd_wd   = '0;
    bit   last_is_d = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_read && m_write) check("strobe_exclusive", 32'd1, 32'd0);
        if (m_read) rd_hi++;
        if (m_read || m_write) begin
            strobe_hi++;
            cmd_addr = m_addr;
            cmd_be   = m_byteenable;
            cmd_wd   = m_writedata;
        end
        if (i_done || d_done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", {30'd0, d_done, i_done}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.name, "_port"}, {30'd0, d_done, i_done}, e.is_d ? 32'd2 : 32'd1);
                check({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
                if (e.chk) check({e.name, "_rdata"}, rdata, e.data);
                check({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic expect_done(input bit is_d, input bit e_err, input bit chk,
                               input logic [31:0] data, input int lat, input string nm);
        exp_t e;
        e.is_d = is_d; e.err = e_err; e.chk = chk; e.data = data;
        e.cyc = cyc + lat; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic start_i(input logic [31:0] a);
        i_req  = 1'b1;
        i_addr = a;
    endtask

    task automatic start_d(input bit w, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        d_req        = 1'b1;
        d_write      = w;
        d_addr       = a;
        d_byteenable = be;
        d_writedata  = wd;
    endtask

    task automatic wait_done(input bit is_d);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (is_d ? d_done : i_done) begin
                if (is_d) d_req = 1'b0; else i_req = 1'b0;
                return;
            end
        end
        check(is_d ? "timeout_d" : "timeout_i", 32'd1, 32'd0);
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
    endtask

    task automatic sim_round(input int r);
        bit win_d;
        win_d = RR ? !last_is_d : 1'b1;
        start_d(1'b1, 32'h30, 4'hF, 32'h12340000 + r);
        start_i(32'h10);
        if (win_d) begin
            expect_done(1'b1, 1'b0, 1'b0, 32'd0, 2, "sim_d_first");
            expect_done(1'b0, 1'b0, 1'b1, 32'h8C010004, 6, "sim_i_second");
        end else begin
            expect_done(1'b0, 1'b0, 1'b1, 32'h8C010004, 3, "sim_i_first");
            expect_done(1'b1, 1'b0, 1'b0, 32'd0, 6, "sim_d_second");
        end
        fork
            wait_done(1'b0);
            wait_done(1'b1);
        join
        @(posedge clk); #1;
        last_is_d = !win_d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected earlier finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, st0;
        reset_n = 1'b0; wait_cfg = 0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_byteenable = '0; d_writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_read", {31'd0, m_read}, 32'd0);
        check("rst_m_write", {31'd0, m_write}, 32'd0);
        check("rst_dones_err", {29'd0, i_done, d_done, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_m_addr", {8'd0, m_addr}, 32'd0);
        check("rst_m_be_wd", {28'd0, m_byteenable} | m_writedata, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // fetch, no wait states
        rd0 = rd_hi;
        start_i(32'h10);
        expect_done(1'b0, 1'b0, 1'b1, 32'h8C010004, 3, "fetch");
        wait_done(1'b0);
        @(posedge clk); #1;
        check("fetch_m_addr", {8'd0, cmd_addr}, 32'h10);
        check("fetch_m_be", {28'd0, cmd_be}, 32'hF);
        check("fetch_read_cycles", rd_hi - rd0, 32'd1);
        last_is_d = 1'b0;

        // partial-lane write
        st0 = strobe_hi;
        start_d(1'b1, 32'h20, 4'b0011, 32'hDEADBEEF);
        expect_done(1'b1, 1'b0, 1'b0, 32'd0, 2, "write");
        wait_done(1'b1);
        @(posedge clk); #1;
        check("write_m_wd", cmd_wd, 32'hDEADBEEF);
        check("write_m_be", {28'd0, cmd_be}, 32'h3);
        check("write_strobe_cycles", strobe_hi - st0, 32'd1);
        last_is_d = 1'b1;

        // read back
        start_d(1'b0, 32'h20, 4'hF, 32'd0);
        expect_done(1'b1, 1'b0, 1'b1, 32'h0000BEEF, 3, "readback");
        wait_done(1'b1);
        @(posedge clk); #1;

        // zero byte-enable: no bus command, zero data
        st0 = strobe_hi;
        start_d(1'b0, 32'h20, 4'b0000, 32'd0);
        expect_done(1'b1, 1'b0, 1'b1, 32'd0, 2, "null_be");
        wait_done(1'b1);
        @(posedge clk); #1;
        check("null_be_strobes", strobe_hi - st0, 32'd0);

        sim_round(0);
        sim_round(1);

        // three wait states
        rd0 = rd_hi;
        wait_cfg = 3;
        start_i(32'h10);
        expect_done(1'b0, 1'b0, 1'b1, 32'h8C010004, 6, "wait3");
        wait_done(1'b0);
        @(posedge clk); #1;
        wait_cfg = 0;
        check("wait3_read_cycles", rd_hi - rd0, 32'd4);
        last_is_d = 1'b0;

        // stall past WAIT_MAX -> abort
        rd0 = rd_hi;
        wait_cfg = 20;
        start_d(1'b0, 32'h20, 4'hF, 32'd0);
        expect_done(1'b1, 1'b1, 1'b1, 32'd0, 6, "abort");
        wait_done(1'b1);
        @(posedge clk); #1;
        wait_cfg = 0;
        check("abort_read_cycles", rd_hi - rd0, 32'd5);
        last_is_d = 1'b1;

        // reset in the middle of a stalled command
        wait_cfg = 20;
        start_i(32'h10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_m_read", {31'd0, m_read}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_m_read", {31'd0, m_read}, 32'd0);
        check("midrst_m_addr", {8'd0, m_addr}, 32'd0);
        check("midrst_done", {30'd0, i_done, d_done}, 32'd0);
        @(posedge clk); #1;
        reset_n  = 1'b1;
        wait_cfg = 0;
        last_is_d = 1'b0;
        expect_done(1'b0, 1'b0, 1'b1, 32'h8C010004, 3, "post_rst_fetch");
        wait_done(1'b0);
        @(posedge clk); #1;
        last_is_d = 1'b0;

        sim_round(2);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
MIPS_CPU_BUS_ARBITER -- requirements
Module: mips_cpu_bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 255: maximum consecutive cycles m_waitrequest may hold one command before the command is aborted.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port i_req, input, 1: instruction-fetch read request; held with i_addr until i_done.
REQ-005 SHALL have port i_addr, input, 32: fetch byte address.
REQ-006 SHALL have port i_done, output, 1: one-cycle completion pulse for the fetch port.
REQ-007 SHALL have port d_req, input, 1: data request; held with its fields until d_done.
REQ-008 SHALL have port d_write, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port d_addr, input, 32: data byte address.
REQ-010 SHALL have port d_byteenable, input, 4: data lane enables.
REQ-011 SHALL have port d_writedata, input, 32: store data.
REQ-012 SHALL have port d_done, output, 1: one-cycle completion pulse for the data port.
REQ-013 SHALL have port rdata, output, 32: read data; valid in the cycle a read's done pulse is high.
REQ-014 SHALL have port err, output, 1: high with the done pulse when that access was aborted.
REQ-015 SHALL have port m_read, output, 1: memory read strobe.
REQ-016 SHALL have port m_write, output, 1: memory write strobe.
REQ-017 SHALL have port m_addr, output, 24: memory address, equal to the granted request's address bits [23:0].
REQ-018 SHALL have port m_byteenable, output, 4: fetch uses 4'b1111; data uses d_byteenable.
REQ-019 SHALL have port m_writedata, output, 32: d_writedata.
REQ-020 SHALL have port m_waitrequest, input, 1: memory stall; the command is accepted on the first posedge where it is low.
REQ-021 SHALL have port m_readdata, input, 32: registered memory data, valid one cycle after read acceptance.

Function
REQ-022 SHALL implement FSM IDLE -> CMD -> (read: RESP | write: DONE) -> DONE -> IDLE; all outputs registered.
REQ-023 IDLE: with any request pending, grant per REQ-031 and load m_* registers; enter CMD next cycle.
REQ-024 CMD: assert exactly one of m_read/m_write and hold all m_* stable while m_waitrequest=1.
REQ-025 CMD: on acceptance, deassert strobes; reads enter RESP, writes enter DONE.
REQ-026 RESP: capture m_readdata into rdata at end of cycle.
REQ-027 DONE: pulse the granted port's done for exactly one cycle, then return to IDLE; a request held high is re-arbitrated in that IDLE cycle.
REQ-028 Latency with zero wait states: request visible in IDLE at cycle N; read done at N+3; write done at N+2; each wait-state cycle adds one.
REQ-029 Data request with d_byteenable=4'b0000 SHALL skip CMD, issue no strobe, and pulse d_done with err=0 two cycles after IDLE sampling; rdata = 0.
REQ-030 An 8-bit wait counter SHALL clear on CMD entry; when it reaches WAIT_MAX with m_waitrequest still high, drop strobes, set rdata=0, and pulse done with err=1.
REQ-031 Simultaneous i_req and d_req in IDLE: d port wins (fixed priority) unless REQ-035 applies.
REQ-032 m_read and m_write SHALL never be high together; both stay low outside CMD.

Reset
REQ-033 reset_n=0 SHALL immediately force IDLE, deassert m_read, m_write, i_done, d_done, err, and zero rdata, m_addr, m_byteenable, m_writedata, the wait counter and the last-grant flag, including mid-CMD.

Configuration
REQ-034 Macro MIPS_CPU_BUS_ARB_RR_EN selects the arbitration policy.
REQ-035 Defined: on simultaneous requests, grant the port not granted last; last-grant flag resets to i (so d wins first). Undefined: fixed d-over-i priority, and the flag is absent.

Structure
REQ-036 Shared package mips_cpu_bus_pkg SHALL hold the FSM state enum (IDLE, CMD, RESP, DONE), the port-id enum (PORT_I, PORT_D), and the constants MEM_ADDR_W=24 and BYTEEN_ALL=4'b1111.
REQ-037 No sub-module; single flat module.

Verification
REQ-038 Fetch i_addr=0x00000010 with memory word 0x8C010004 and no waits -> m_read pulse with m_addr=0x000010, m_byteenable=1111; i_done at +3 cycles with rdata=0x8C010004.
REQ-039 Data write, addr=0x20, byteenable=0011, data=0xDEADBEEF -> m_write one cycle; d_done at +2 cycles; a later read of 0x20 with 1111 returns 0x0000BEEF.
REQ-040 i_req and d_req rise together -> d served first, then i; with MIPS_CPU_BUS_ARB_RR_EN, repeated simultaneous requests alternate d,i,d,i.
REQ-041 m_waitrequest held high for 3 cycles on a read -> m_read held stable 4 cycles; done at +6 with correct data, err=0; held past WAIT_MAX=4 -> done with err=1, rdata=0.
REQ-042 reset_n pulsed low during CMD -> strobes drop within the same cycle, no done pulse; the pending request is served normally after release.
